sync_fifo: RTL and testbench

Single-clock first-in/first-out buffer with registered read data and standard (non-first-word-fall-through) read timing. It uses full/empty handshaking and has a parameterised width, depth and output pipeline. It is used as a general-purpose data buffer, e.g. inside the I2C/AXI controller datapaths. Its port behaviour matches a vendor synchronous FIFO in standard read mode, so it can be swapped for one.

---
 rtl/sync_fifo_pkg.sv | 11 +
 rtl/sync_fifo_if.sv | 37 +++
 rtl/sync_fifo_ram.sv | 33 +++
 rtl/sync_fifo.sv | 118 +++++++++++
 tb/tb_sync_fifo.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo shared package: pointer width helper and pipeline limit.
// Optional flag outputs are enabled with SYNC_FIFO_FLAGS_EN.
package sync_fifo_pkg;

  localparam int R_MAX = 4;

  function automatic int ptr_w(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo data/handshake bundle with producer/consumer views.
// data_count/overflow/underflow exist only with SYNC_FIFO_FLAGS_EN.
interface sync_fifo_if #(
  parameter int W = 16,
  parameter int D = 64
) ();
  import sync_fifo_pkg::*;

  logic [W-1:0] din;
  logic         wr_en;
  logic         full;
  logic         rd_en;
  logic [W-1:0] dout;
  logic         empty;
`ifdef SYNC_FIFO_FLAGS_EN
  logic [ptr_w(D)-1:0] data_count;
  logic                overflow;
  logic                underflow;
`endif

  modport master (
    output din, wr_en, rd_en,
`ifdef SYNC_FIFO_FLAGS_EN
    input  data_count, overflow, underflow,
`endif
    input  full, dout, empty
  );

  modport slave (
    input  din, wr_en, rd_en,
`ifdef SYNC_FIFO_FLAGS_EN
    output data_count, overflow, underflow,
`endif
    output full, dout, empty
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo storage: simple dual-port RAM, one write port and one
// read port with a registered output that resets to zero.
module sync_fifo_ram #(
  parameter int W = 16,
  parameter int D = 64
) (
  input  logic                 clk,
  input  logic                 srst_n,
  input  logic                 we_i,
  input  logic [$clog2(D)-1:0] waddr_i,
  input  logic [W-1:0]         wdata_i,
  input  logic                 re_i,
  input  logic [$clog2(D)-1:0] raddr_i,
  output logic [W-1:0]         rdata_o
);

  logic [W-1:0] mem_q [D];
  logic [W-1:0] rdata_q;

  // Array write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Output register only loads on an accepted read
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo top: pointers, registered flags, read pipeline.
// Define SYNC_FIFO_FLAGS_EN for data_count/overflow/underflow.
module sync_fifo #(
  parameter int W = 16,
  parameter int D = 64,
  parameter int R = 0
) (
  input  logic      clk,
  input  logic      srst_n,
  sync_fifo_if.slave bus
);
  import sync_fifo_pkg::*;

  localparam int PW = ptr_w(D);
  localparam int AW = PW - 1;
  localparam int RP = (R > R_MAX) ? R_MAX :
                      ((R < 0) ? 0 : R);
  localparam logic [PW-1:0] ONE = PW'(1);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          wr_acc, rd_acc;
  logic [W-1:0]  ram_rdata;

  // Accept decisions and next pointers/flags
  always_comb begin
    wr_acc  = bus.wr_en && !full_q;
    rd_acc  = bus.rd_en && !empty_q;
    wptr_d  = wr_acc ? wptr_q + ONE : wptr_q;
    rptr_d  = rd_acc ? rptr_q + ONE : rptr_q;
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AW] != rptr_d[AW]) &&
              (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  end

  // Pointer and flag registers
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  sync_fifo_ram #(
    .W (W),
    .D (D)
  ) u_ram (
    .clk     (clk),
    .srst_n  (srst_n),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (bus.din),
    .re_i    (rd_acc),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  generate
    if (RP == 0) begin : g_nopipe
      assign bus.dout = ram_rdata;
    end else begin : g_pipe
      logic [W-1:0] pipe_q [RP];

      // Free-running delay line behind the RAM register
      always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
          for (int i = 0; i < RP; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= ram_rdata;
          for (int i = 1; i < RP; i++)
            pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign bus.dout = pipe_q[RP-1];
    end
  endgenerate

  assign bus.full  = full_q;
  assign bus.empty = empty_q;

`ifdef SYNC_FIFO_FLAGS_EN
  logic [PW-1:0] cnt_q, cnt_d;
  logic          ovf_q, unf_q;

  // Pointer difference is the occupancy, 0..D
  always_comb begin
    cnt_d = wptr_d - rptr_d;
  end

  // Occupancy and one-cycle reject pulses
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= bus.wr_en && full_q;
      unf_q <= bus.rd_en && empty_q;
    end
  end

  assign bus.data_count = cnt_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// sync_fifo bench: vector table, directed corners, random vs queue model.
// Optional flag checks follow SYNC_FIFO_FLAGS_EN.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int W = 16;
  localparam int D = 1024;
  localparam int R = 2;

  logic clk = 1'b0;
  logic srst_n;

  always #5 clk = ~clk;

  sync_fifo_if #(.W(W), .D(D)) bus ();

  sync_fifo #(
    .W (W),
    .D (D),
    .R (R)
  ) dut (
    .clk    (clk),
    .srst_n (srst_n),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] last_rd;
  bit           exp_ovf;
  bit           exp_unf;

  typedef struct {
    bit           wr;
    bit           rd;
    logic [W-1:0] din;
    bit           e_empty;
    bit           e_full;
    logic [W-1:0] e_rd;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    hist.delete();
    last_rd = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  function automatic logic [W-1:0] exp_dout();
    if (hist.size() <= R) return '0;
    return hist[0];
  endfunction

  task automatic cycle(input bit wr, input bit rd,
                       input logic [W-1:0] d);
    bit m_full, m_empty;
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.din   = d;
    @(posedge clk);
    if (srst_n) begin
      m_full  = (mq.size() == D);
      m_empty = (mq.size() == 0);
      exp_ovf = wr && m_full;
      exp_unf = rd && m_empty;
      if (rd && !m_empty) last_rd = mq.pop_front();
      if (wr && !m_full) mq.push_back(d);
      hist.push_back(last_rd);
      while (hist.size() > R + 1) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic check_all(input string nm);
    chk({nm, " dout"}, 64'(bus.dout), 64'(exp_dout()));
    chk({nm, " empty"}, 64'(bus.empty), 64'(mq.size() == 0));
    chk({nm, " full"}, 64'(bus.full), 64'(mq.size() == D));
`ifdef SYNC_FIFO_FLAGS_EN
    chk({nm, " count"}, 64'(bus.data_count), 64'(mq.size()));
    chk({nm, " ovf"}, 64'(bus.overflow), 64'(exp_ovf));
    chk({nm, " unf"}, 64'(bus.underflow), 64'(exp_unf));
`endif
  endtask

  task automatic do_reset(input int n);
    srst_n = 1'b0;
    #1;
    chk("async rst empty", 64'(bus.empty), 64'd1);
    chk("async rst full", 64'(bus.full), 64'd0);
    chk("async rst dout", 64'(bus.dout), 64'd0);
    for (int i = 0; i < n; i++) begin
      cycle(1'($urandom), 1'($urandom), W'($urandom));
      chk("rst empty", 64'(bus.empty), 64'd1);
      chk("rst full", 64'(bus.full), 64'd0);
      chk("rst dout", 64'(bus.dout), 64'd0);
`ifdef SYNC_FIFO_FLAGS_EN
      chk("rst count", 64'(bus.data_count), 64'd0);
`endif
    end
    model_reset();
    srst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] cnt;

    tbl[0]  = '{1, 0, 16'h0011, 0, 0, 16'h0000};
    tbl[1]  = '{0, 0, 16'h0000, 0, 0, 16'h0000};
    tbl[2]  = '{0, 1, 16'h0000, 1, 0, 16'h0011};
    tbl[3]  = '{0, 1, 16'h0000, 1, 0, 16'h0011};
    tbl[4]  = '{1, 1, 16'h00AA, 0, 0, 16'h0011};
    tbl[5]  = '{1, 1, 16'h00BB, 0, 0, 16'h00AA};
    tbl[6]  = '{1, 0, 16'h00CC, 0, 0, 16'h00AA};
    tbl[7]  = '{0, 1, 16'h0000, 0, 0, 16'h00BB};
    tbl[8]  = '{1, 0, 16'h00DD, 0, 0, 16'h00BB};
    tbl[9]  = '{0, 1, 16'h0000, 0, 0, 16'h00CC};
    tbl[10] = '{0, 1, 16'h0000, 1, 0, 16'h00DD};
    tbl[11] = '{1, 1, 16'h00EE, 0, 0, 16'h00DD};
    tbl[12] = '{0, 1, 16'h0000, 1, 0, 16'h00EE};

    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;
    srst_n    = 1'b1;
    model_reset();
    #2;

    do_reset(100);

    // Vector table: apply, let the pipeline settle, compare
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].wr, tbl[i].rd, tbl[i].din);
      repeat (R) cycle(1'b0, 1'b0, '0);
      chk($sformatf("vec%0d dout", i),
          64'(bus.dout), 64'(tbl[i].e_rd));
      chk($sformatf("vec%0d empty", i),
          64'(bus.empty), 64'(tbl[i].e_empty));
      chk($sformatf("vec%0d full", i),
          64'(bus.full), 64'(tbl[i].e_full));
      check_all($sformatf("vec%0d model", i));
    end

    // Read latency of 1+R cycles
    chk("lat pre empty", 64'(bus.empty), 64'd1);
    cycle(1'b1, 1'b0, 16'h0001);
    chk("lat empty fall", 64'(bus.empty), 64'd0);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, '0);
    for (int k = 0; k <= R; k++) begin
      chk($sformatf("lat dout+%0d", k), 64'(bus.dout),
          (k == R) ? 64'h0001 : 64'h00EE);
      if (k < R) cycle(1'b0, 1'b0, '0);
    end
    chk("lat empty end", 64'(bus.empty), 64'd1);

    // Fill to full, overflow, simultaneous at full, drain
    for (int i = 0; i < D; i++) begin
      cycle(1'b1, 1'b0, W'(i));
      if (i == D - 2)
        chk("fill full early", 64'(bus.full), 64'd0);
    end
    chk("fill full", 64'(bus.full), 64'd1);
    chk("fill empty", 64'(bus.empty), 64'd0);
    cycle(1'b1, 1'b0, 16'hBEEF);
    chk("ovf full held", 64'(bus.full), 64'd1);
    check_all("ovf");
    cycle(1'b1, 1'b1, 16'h1234);
    chk("both@full full", 64'(bus.full), 64'd0);
    check_all("both@full");
    repeat (R) cycle(1'b0, 1'b0, '0);
    chk("both@full dout", 64'(bus.dout), 64'd0);
    for (int i = 1; i < D; i++) begin
      cycle(1'b0, 1'b1, '0);
      chk("drain dout", 64'(bus.dout),
          (i > R) ? 64'(i - R) : 64'd0);
    end
    repeat (R) cycle(1'b0, 1'b0, '0);
    chk("drain last", 64'(bus.dout), 64'(D - 1));
    chk("drain empty", 64'(bus.empty), 64'd1);
    cycle(1'b0, 1'b1, '0);
    chk("unf dout held", 64'(bus.dout), 64'(D - 1));
    check_all("unf");

    // Random traffic with a mid-run reset
    cnt = '0;
    for (int c = 0; c < 20000; c++) begin
      if (c == 10000) do_reset(3);
      cycle(1'($urandom), 1'($urandom), cnt);
      cnt = cnt + 1'b1;
      check_all("rand");
    end

    // Reset mid-operation discards queued words
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'(16'h7000 + i));
    do_reset(2);
    cycle(1'b1, 1'b0, 16'h5A5A);
    cycle(1'b0, 1'b1, '0);
    repeat (R) cycle(1'b0, 1'b0, '0);
    chk("post-rst read", 64'(bus.dout), 64'h5A5A);
    chk("post-rst empty", 64'(bus.empty), 64'd1);
    check_all("post-rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
